rst_seq: RTL and testbench

RST_SEQ -- requirements
Module: rst_seq

---
 rtl/rst_seq_pkg.sv | 20 ++
 rtl/rst_cnt.sv | 22 ++
 rtl/rst_seq.sv | 125 ++++++++++++
 tb/tb_rst_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM state and last-reset-cause encodings.
package rst_seq_pkg;

   localparam int STATE_W = 2;
   localparam int CAUSE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      HOLD  = 2'd0,
      REL_P = 2'd1,
      REL_M = 2'd2,
      RUN   = 2'd3
   } state_t;

   typedef enum logic [CAUSE_W-1:0] {
      CAUSE_POR  = 2'd0,
      CAUSE_LOCK = 2'd1,
      CAUSE_SOFT = 2'd2
   } cause_t;

endpackage

// File: rtl/rst_cnt.sv
// Cycle counter for the reset sequencer; clear has priority over enable.
module rst_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/rst_seq.sv
// Staged reset release: peripheral, then memory, then core, once the clock has been
// locked for HOLD_CYCLES; lock loss or a soft request restarts the sequence.
//
// state | meaning
// ------+---------------------------------------------------------------
// HOLD  | all resets asserted, counting consecutive locked cycles
// REL_P | peripheral released, waiting GAP_CYCLES
// REL_M | peripheral and memory released, waiting GAP_CYCLES
// RUN   | all resets released, ready asserted
module rst_seq
   import rst_seq_pkg::*;
#(
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 4,
   parameter int CNT_W       = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               lock,
   input  logic               soft_req,
   output logic               reset_periph,
   output logic               reset_mem,
   output logic               reset_core,
   output logic               ready,
   output logic [STATE_W-1:0] seq_state,
   output logic [CAUSE_W-1:0] rst_cause
);

   if (HOLD_CYCLES < 1 || HOLD_CYCLES > (2**CNT_W) - 1) begin : g_bad_hold
      $error("rst_seq: HOLD_CYCLES out of range for CNT_W");
   end
   if (GAP_CYCLES < 1 || GAP_CYCLES > (2**CNT_W) - 1) begin : g_bad_gap
      $error("rst_seq: GAP_CYCLES out of range for CNT_W");
   end

   localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_CYCLES - 1);

   state_t           state_q, state_d;
   cause_t           cause_q, cause_d;
   logic             cnt_clr, cnt_en;
   logic [CNT_W-1:0] cnt;
   logic             periph_d, mem_d, core_d, ready_d;

   rst_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (cnt_clr),
      .enable (cnt_en),
      .count  (cnt)
   );

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state_q)
         HOLD: begin
            // soft_req is deliberately not looked at while still holding
            if (!lock) begin
               cnt_clr = 1'b1;
            end else if (cnt == HOLD_TC) begin
               state_d = REL_P;
               cnt_clr = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         REL_P, REL_M, RUN: begin
            // lock loss outranks a simultaneous soft request
            if (!lock) begin
               state_d = HOLD;
               cause_d = CAUSE_LOCK;
               cnt_clr = 1'b1;
            end else if (soft_req) begin
               state_d = HOLD;
               cause_d = CAUSE_SOFT;
               cnt_clr = 1'b1;
            end else if (state_q != RUN) begin
               if (cnt == GAP_TC) begin
                  state_d = (state_q == REL_P) ? REL_M : RUN;
                  cnt_clr = 1'b1;
               end else begin
                  cnt_en = 1'b1;
               end
            end
         end
         default: begin
            state_d = HOLD;
            cnt_clr = 1'b1;
         end
      endcase

      // decoded from the next state so registered outputs move with the state
      periph_d = (state_d == HOLD);
      mem_d    = (state_d == HOLD) || (state_d == REL_P);
      core_d   = (state_d != RUN);
      ready_d  = (state_d == RUN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= HOLD;
         cause_q      <= CAUSE_POR;
         reset_periph <= 1'b1;
         reset_mem    <= 1'b1;
         reset_core   <= 1'b1;
         ready        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cause_q      <= cause_d;
         reset_periph <= periph_d;
         reset_mem    <= mem_d;
         reset_core   <= core_d;
         ready        <= ready_d;
      end
   end

   assign seq_state = state_q;
   assign rst_cause = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Randomised and directed bench for rst_seq against a timeline model of the release sequence.
module tb_rst_seq;

   localparam int H = 16;
   localparam int G = 4;

   logic       clk;
   logic       reset;
   logic       lock;
   logic       soft_req;
   logic       reset_periph, reset_mem, reset_core, ready;
   logic [1:0] seq_state, rst_cause;

   int compared   = 0;
   int mismatched = 0;

   // model: t = cycles into the release timeline, saturating at full release
   int         m_t     = 0;
   logic [1:0] m_cause = 2'd0;

   logic [7:0] exp_q[$];

   rst_seq #(
      .HOLD_CYCLES (H),
      .GAP_CYCLES  (G),
      .CNT_W       (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .lock         (lock),
      .soft_req     (soft_req),
      .reset_periph (reset_periph),
      .reset_mem    (reset_mem),
      .reset_core   (reset_core),
      .ready        (ready),
      .seq_state    (seq_state),
      .rst_cause    (rst_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] model_vec();
      logic [1:0] st;
      logic       p, m, c;
      p  = (m_t < H);
      m  = (m_t < H + G);
      c  = (m_t < H + 2*G);
      st = (m_t < H) ? 2'd0 : (m_t < H + G) ? 2'd1 : (m_t < H + 2*G) ? 2'd2 : 2'd3;
      return {p, m, c, ~c, st, m_cause};
   endfunction

   function automatic logic [7:0] dut_vec();
      return {reset_periph, reset_mem, reset_core, ready, seq_state, rst_cause};
   endfunction

   task automatic model_apply(input bit r, input bit l, input bit s);
      if (r) begin
         m_t     = 0;
         m_cause = 2'd0;
      end else if (m_t < H) begin
         m_t = l ? m_t + 1 : 0;
      end else if (!l) begin
         m_t     = 0;
         m_cause = 2'd1;
      end else if (s) begin
         m_t     = 0;
         m_cause = 2'd2;
      end else if (m_t < H + 2*G) begin
         m_t = m_t + 1;
      end
   endtask

   task automatic step(input bit r, input bit l, input bit s);
      @(negedge clk);
      reset    = r;
      lock     = l;
      soft_req = s;
      model_apply(r, l, s);
      exp_q.push_back(model_vec());
   endtask

   task automatic run_locked(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
   endtask

   always @(posedge clk) begin
      logic [7:0] e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         if (dut_vec() !== e) begin
            mismatched++;
            $display("FAIL cycle_check @%0t: got {rp,rm,rc,rdy,st,cause}=%b required %b",
                     $time, dut_vec(), e);
         end
      end
   end

   initial begin
      reset    = 1'b1;
      lock     = 1'b1;
      soft_req = 1'b0;

      // power-on release with lock held throughout
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
      run_locked(30);

      // single-cycle lock glitch while holding restarts the count
      for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0);
      run_locked(9);
      step(1'b0, 1'b0, 1'b0);
      run_locked(30);

      // soft request in RUN
      step(1'b0, 1'b1, 1'b1);
      run_locked(30);

      // lock loss during REL_M
      for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0);
      run_locked(21);
      step(1'b0, 1'b0, 1'b0);
      run_locked(30);

      // lock loss together with soft request in RUN
      step(1'b0, 1'b0, 1'b1);
      run_locked(30);

      // soft request while holding is ignored
      step(1'b0, 1'b1, 1'b1);
      run_locked(5);
      step(1'b0, 1'b1, 1'b1);
      run_locked(30);

      // async reset between edges while in RUN
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      m_t     = 0;
      m_cause = 2'd0;
      compared++;
      if (dut_vec() !== 8'b1110_0000) begin
         mismatched++;
         $display("FAIL async_reset: got %b required %b", dut_vec(), 8'b1110_0000);
      end
      for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0);

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(0, 499) == 0),
              ($urandom_range(0, 59) != 0),
              ($urandom_range(0, 39) == 0));
      end

      @(posedge clk);
      #2;
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
